serial_adder: RTL

//   Bit-serial WIDTH-bit adder built around the existing 1-bit full_adder cell.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_full_adder.sv | 14 +
 rtl/serial_adder.sv | 108 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encodings and the legal WIDTH range.
package serial_adder_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder cell.
// Used once per clock by the serial adder loop.
module full_adder (
  input  logic ain,
  input  logic bin,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = ain ^ bin ^ cin;
  assign cout = (ain & bin) | (cin & (ain ^ bin));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, with a carry flop loop.
// Define SERIAL_ADDER_OVF_EN to add the two's-complement ovf output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = WIDTH - 1;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t state, state_nxt;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [SW-1:0]    s_sr;
  logic             carry;
  logic             s, co;
  logic             accept, last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == SHIFT) && (count == CW'(WIDTH - 1));
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  full_adder u_fa (
    .ain  (a_sr[0]),
    .bin  (b_sr[0]),
    .cin  (carry),
    .sum  (s),
    .cout (co)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter stops on the final edge so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        count <= '0;
      end else if (state == SHIFT && !last) begin
        count <= count + CW'(1);
      end
    end
  end

  // s_sr keeps only the upper WIDTH-1 result bits; the final s completes sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= SW'({s, s_sr} >> 1);
      carry <= co;
      if (last) begin
        sum  <= {s, s_sr};
        cout <= co;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  <= carry ^ co;
`endif
      end
    end
  end

endmodule
